// File: rtl/connect4_pkg.sv
// connect4_pkg: types and board dimensions shared by the Connect-4 game blocks.
//   COLS / ROWS : default board size (module parameters default to these)
//   state_t     : move controller states
//   player_t    : player identifier, 0 or 1
package connect4_pkg;

  localparam int COLS = 7;
  localparam int ROWS = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLACE = 2'd1,
    OVER  = 2'd2
  } state_t;

  typedef logic player_t;

endpackage

// File: rtl/column_heights.sv
// column_heights: one fill-height counter per board column.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   clr                 synchronous clear of every height (wins over inc)
//   inc, inc_col        add one disc to column inc_col (saturates at ROWS)
//   rd_col              column to read
//   rd_height, rd_full  height of rd_col and whether it has reached ROWS
module column_heights #(
  parameter  int COLS = connect4_pkg::COLS,
  parameter  int ROWS = connect4_pkg::ROWS,
  localparam int CW   = $clog2(COLS),
  localparam int HW   = $clog2(ROWS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic [CW-1:0] inc_col,
  input  logic [CW-1:0] rd_col,
  output logic [HW-1:0] rd_height,
  output logic          rd_full
);

  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  localparam logic [HW-1:0] FULL_H   = HW'(ROWS);

  logic [HW-1:0] height_q [COLS];
  logic [HW-1:0] height_d [COLS];

  always_comb begin
    // NOTE: every element gets a default before any branch, otherwise the
    // untouched columns would infer latches.
    for (int c = 0; c < COLS; c++) begin
      height_d[c] = height_q[c];
    end
    if (clr) begin
      for (int c = 0; c < COLS; c++) begin
        height_d[c] = '0;
      end
    end else if (inc && (inc_col <= LAST_COL) && (height_q[inc_col] != FULL_H)) begin
      height_d[inc_col] = height_q[inc_col] + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: this array is game state, not a data buffer: every entry must
      // come out of reset at zero, so it is reset like any other flop.
      for (int c = 0; c < COLS; c++) begin
        height_q[c] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignment so all flops update together at the edge.
      height_q <= height_d;
    end
  end

  assign rd_height = (rd_col <= LAST_COL) ? height_q[rd_col] : '0;
  assign rd_full   = (rd_height == FULL_H);

endmodule

// File: rtl/move_controller.sv
// move_controller: turns one-hot left/right/put pulses into Connect-4 moves.
// Tracks cursor, column heights, player to move and move count, and offers
// each legal drop downstream over a valid/ready handshake.
// Build option: define CURSOR_WRAP_EN to make the cursor wrap at the board
// edges; by default it saturates at column 0 and COLS-1.
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   lrp              one-hot pulses [2] left, [1] right, [0] put
//   new_game         synchronous clear of all game state (highest priority)
//   game_over        level from the win checker, freezes play
//   mv_ready         downstream accepts the move
//   mv_valid         move request valid (held until mv_ready)
//   mv_col/row       landing column / row (row 0 = bottom)
//   mv_player        player making the move
//   cursor, player   current cursor column, player to move
//   col_full         cursor column is full
//   board_full       all COLS*ROWS cells are filled
module move_controller
  import connect4_pkg::*;
#(
  parameter int COLS = connect4_pkg::COLS,
  parameter int ROWS = connect4_pkg::ROWS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              lrp,
  input  logic                    new_game,
  input  logic                    game_over,
  input  logic                    mv_ready,
  output logic                    mv_valid,
  output logic [$clog2(COLS)-1:0] mv_col,
  output logic [$clog2(ROWS)-1:0] mv_row,
  output logic                    mv_player,
  output logic [$clog2(COLS)-1:0] cursor,
  output logic                    player,
  output logic                    col_full,
  output logic                    board_full
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int HW = $clog2(ROWS + 1);
  localparam int NW = $clog2(COLS * ROWS + 1);

  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  localparam logic [CW-1:0] MID_COL  = CW'(COLS / 2);
  localparam logic [NW-1:0] CELLS    = NW'(COLS * ROWS);

  state_t        state_q,     state_d;
  logic [CW-1:0] cursor_q,    cursor_d;
  player_t       player_q,    player_d;
  logic [NW-1:0] count_q,     count_d;
  logic [CW-1:0] mv_col_q,    mv_col_d;
  logic [RW-1:0] mv_row_q,    mv_row_d;
  player_t       mv_player_q, mv_player_d;

  logic [HW-1:0] cur_height;
  logic          cur_full;
  logic          handshake;
  logic [NW-1:0] count_inc;

  assign handshake = (state_q == PLACE) && mv_ready;
  assign count_inc = count_q + 1'b1;

  // Heights clear on new_game even if a handshake lands in the same cycle,
  // so a dropped move never leaves a disc behind.
  column_heights #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_heights (
    .clk       (clk),
    .rst       (rst),
    .clr       (new_game),
    .inc       (handshake),
    .inc_col   (mv_col_q),
    .rd_col    (cursor_q),
    .rd_height (cur_height),
    .rd_full   (cur_full)
  );

  always_comb begin
    state_d     = state_q;
    cursor_d    = cursor_q;
    player_d    = player_q;
    count_d     = count_q;
    mv_col_d    = mv_col_q;
    mv_row_d    = mv_row_q;
    mv_player_d = mv_player_q;

    if (new_game) begin
      state_d  = IDLE;
      cursor_d = MID_COL;
      player_d = 1'b0;
      count_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Left beats right beats put when several pulses coincide.
          if (game_over) begin
            state_d = OVER;
          end else if (lrp[2]) begin
            if (cursor_q != '0) begin
              cursor_d = cursor_q - 1'b1;
            end else begin
`ifdef CURSOR_WRAP_EN
              cursor_d = LAST_COL;
`else
              cursor_d = cursor_q;
`endif
            end
          end else if (lrp[1]) begin
            if (cursor_q != LAST_COL) begin
              cursor_d = cursor_q + 1'b1;
            end else begin
`ifdef CURSOR_WRAP_EN
              cursor_d = '0;
`else
              cursor_d = cursor_q;
`endif
            end
          end else if (lrp[0] && !cur_full) begin
            // A non-full column has height < ROWS, which always fits in RW bits.
            mv_col_d    = cursor_q;
            mv_row_d    = RW'(cur_height);
            mv_player_d = player_q;
            state_d     = PLACE;
          end
        end
        PLACE: begin
          if (mv_ready) begin
            player_d = ~player_q;
            count_d  = count_inc;
            state_d  = (game_over || (count_inc == CELLS)) ? OVER : IDLE;
          end
        end
        OVER:    state_d = OVER;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cursor_q    <= MID_COL;
      player_q    <= 1'b0;
      count_q     <= '0;
      mv_col_q    <= '0;
      mv_row_q    <= '0;
      mv_player_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cursor_q    <= cursor_d;
      player_q    <= player_d;
      count_q     <= count_d;
      mv_col_q    <= mv_col_d;
      mv_row_q    <= mv_row_d;
      mv_player_q <= mv_player_d;
    end
  end

  assign mv_valid   = (state_q == PLACE);
  assign mv_col     = mv_col_q;
  assign mv_row     = mv_row_q;
  assign mv_player  = mv_player_q;
  assign cursor     = cursor_q;
  assign player     = player_q;
  assign col_full   = cur_full;
  assign board_full = (count_q == CELLS);

endmodule

// File: tb/tb_move_controller.sv
// tb_move_controller: directed plus randomized stimulus for move_controller,
// checked against a behavioural game model (cursor, heights, turn, count).
// Honours CURSOR_WRAP_EN the same way as the design.
module tb_move_controller;
  import connect4_pkg::*;

  localparam int TOTAL = COLS * ROWS;
`ifdef CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst;
  logic [2:0]              lrp;
  logic                    new_game;
  logic                    game_over;
  logic                    mv_ready;
  logic                    mv_valid;
  logic [$clog2(COLS)-1:0] mv_col;
  logic [$clog2(ROWS)-1:0] mv_row;
  logic                    mv_player;
  logic [$clog2(COLS)-1:0] cursor;
  logic                    player;
  logic                    col_full;
  logic                    board_full;

  move_controller dut (
    .clk        (clk),
    .rst        (rst),
    .lrp        (lrp),
    .new_game   (new_game),
    .game_over  (game_over),
    .mv_ready   (mv_ready),
    .mv_valid   (mv_valid),
    .mv_col     (mv_col),
    .mv_row     (mv_row),
    .mv_player  (mv_player),
    .cursor     (cursor),
    .player     (player),
    .col_full   (col_full),
    .board_full (board_full)
  );

  always #5 clk = ~clk;

  // Behavioural game model.
  int m_cur;
  int m_pl;
  int m_cnt;
  int m_h [COLS];
  bit m_over;

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cur  = COLS / 2;
    m_pl   = 0;
    m_cnt  = 0;
    m_over = 1'b0;
    for (int c = 0; c < COLS; c++) m_h[c] = 0;
  endtask

  task automatic check_view(input string tag);
    check({tag, ".cursor"},     32'(cursor),     32'(m_cur));
    check({tag, ".player"},     32'(player),     32'(m_pl));
    check({tag, ".col_full"},   32'(col_full),   32'(m_h[m_cur] == ROWS));
    check({tag, ".board_full"}, 32'(board_full), 32'(m_cnt == TOTAL));
    check({tag, ".mv_valid"},   32'(mv_valid),   32'd0);
  endtask

  // One-cycle pulse on lrp; only left/right matter to the model (put is
  // never the winning bit here because bits[2] or bits[1] is always set).
  task automatic press(input logic [2:0] bits, input string tag);
    @(negedge clk) lrp = bits;
    @(negedge clk) lrp = 3'b000;
    if (!m_over) begin
      if (bits[2])      m_cur = (m_cur == 0) ? (WRAP ? COLS - 1 : 0) : m_cur - 1;
      else if (bits[1]) m_cur = (m_cur == COLS - 1) ? (WRAP ? 0 : COLS - 1) : m_cur + 1;
    end
    check_view(tag);
  endtask

  task automatic move_to(input int target);
    for (int k = 0; k < COLS && m_cur != target && !m_over; k++) begin
      press((m_cur < target) ? 3'b010 : 3'b100, "move_to");
    end
  endtask

  // Put at the cursor; mv_ready stays low for wait_cycles PLACE cycles.
  task automatic do_put(input int wait_cycles, input bit inject, input bit raise_go,
                        input string tag);
    bit expect_mv;
    int e_col, e_row, e_pl;
    mv_ready = (wait_cycles == 0);
    @(negedge clk) lrp = 3'b001;
    @(negedge clk) lrp = 3'b000;
    expect_mv = !m_over && (m_h[m_cur] < ROWS);
    check({tag, ".mv_valid"}, 32'(mv_valid), 32'(expect_mv));
    if (!expect_mv) begin
      check_view({tag, ".ignored"});
      return;
    end
    e_col = m_cur;
    e_row = m_h[m_cur];
    e_pl  = m_pl;
    check({tag, ".mv_col"},    32'(mv_col),    32'(e_col));
    check({tag, ".mv_row"},    32'(mv_row),    32'(e_row));
    check({tag, ".mv_player"}, 32'(mv_player), 32'(e_pl));
    for (int i = 0; i < wait_cycles; i++) begin
      if (inject) lrp = (i % 2 == 0) ? 3'b010 : 3'b100;
      if (raise_go && i == 0) game_over = 1'b1;
      @(negedge clk) lrp = 3'b000;
      check({tag, ".held_valid"},  32'(mv_valid),  32'd1);
      check({tag, ".held_col"},    32'(mv_col),    32'(e_col));
      check({tag, ".held_row"},    32'(mv_row),    32'(e_row));
      check({tag, ".held_player"}, 32'(mv_player), 32'(e_pl));
      check({tag, ".held_cursor"}, 32'(cursor),    32'(m_cur));
    end
    mv_ready = 1'b1;
    @(negedge clk);
    m_h[e_col]++;
    m_cnt++;
    m_pl = 1 - m_pl;
    if (game_over || m_cnt == TOTAL) m_over = 1'b1;
    check_view({tag, ".done"});
  endtask

  task automatic start_new_game(input string tag);
    @(negedge clk) new_game = 1'b1;
    @(negedge clk) new_game = 1'b0;
    model_reset();
    check_view(tag);
  endtask

  initial begin
    rst = 1'b0; lrp = '0; new_game = 1'b0; game_over = 1'b0; mv_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check_view("reset");
    check("reset.mv_col",    32'(mv_col),    32'd0);
    check("reset.mv_row",    32'(mv_row),    32'd0);
    check("reset.mv_player", 32'(mv_player), 32'd0);

    // Cursor walk to the left edge, then one more left.
    repeat (2) press(3'b100 ^ 3'b110, "right");
    repeat (5) press(3'b100, "left");
    press(3'b100, "left_edge");
    move_to(COLS - 1);
    press(3'b010, "right_edge");
    press(3'b101, "prio_left_put");
    press(3'b011, "prio_right_put");
    press(3'b111, "prio_all");
    move_to(3);

    // Two puts into column 3, then one with a stalled handshake.
    do_put(0, 1'b0, 1'b0, "put1");
    do_put(0, 1'b0, 1'b0, "put2");
    do_put(5, 1'b1, 1'b0, "put_stall");

    // Fill column 0 and try once more.
    move_to(0);
    repeat (ROWS) do_put(0, 1'b0, 1'b0, "fill_c0");
    check("c0.col_full", 32'(col_full), 32'd1);
    do_put(0, 1'b0, 1'b0, "put_c0_full");

    // game_over during PLACE: move completes, then play is frozen.
    move_to(1);
    do_put(2, 1'b0, 1'b1, "put_gameover");
    do_put(0, 1'b0, 1'b0, "put_after_over");
    press(3'b100, "left_after_over");
    game_over = 1'b0;
    start_new_game("new_game1");

    // new_game while a move is pending drops it.
    mv_ready = 1'b0;
    @(negedge clk) lrp = 3'b001;
    @(negedge clk) lrp = 3'b000;
    check("pend.mv_valid", 32'(mv_valid), 32'd1);
    start_new_game("new_game_drop");
    do_put(0, 1'b0, 1'b0, "put_after_drop");

    // Randomized play.
    start_new_game("new_game_rand");
    for (int n = 0; n < 250 && !m_over; n++) begin
      case ($urandom_range(0, 4))
        0:       press(3'b100, "rnd_left");
        1:       press(3'b010, "rnd_right");
        2:       press(3'($urandom_range(2, 7)), "rnd_multi");
        default: do_put(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, "rnd_put");
      endcase
    end

    // Column-major fill of the whole board.
    start_new_game("new_game_fill");
    for (int c = 0; c < COLS; c++) begin
      move_to(c);
      repeat (ROWS) do_put(0, 1'b0, 1'b0, "fill_all");
    end
    check("fill.board_full", 32'(board_full), 32'd1);
    do_put(0, 1'b0, 1'b0, "put_board_full");
    press(3'b100, "left_board_full");

    // Asynchronous reset while a move is pending.
    start_new_game("new_game_rst");
    move_to(5);
    mv_ready = 1'b0;
    @(negedge clk) lrp = 3'b001;
    @(negedge clk) lrp = 3'b000;
    check("rst_pend.mv_valid", 32'(mv_valid), 32'd1);
    check("rst_pend.mv_col",   32'(mv_col),    32'd5);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_view("async_rst");
    check("async_rst.mv_col",    32'(mv_col),    32'd0);
    check("async_rst.mv_row",    32'(mv_row),    32'd0);
    check("async_rst.mv_player", 32'(mv_player), 32'd0);
    @(negedge clk) rst = 1'b1;
    mv_ready = 1'b1;
    do_put(0, 1'b0, 1'b0, "put_after_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule
